id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 16, datapath width of all data buses.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_rs1 / id_rs2 / id_rd  in  4 each  ID source and destination register numbers.
REQ-006 id_rs1_data / id_rs2_data  in  DATA_W each  register-file read data.
REQ-007 id_imm  in  DATA_W  sign-extended immediate.
REQ-008 id_ctrl  in  8  {alu_op[3:0], alu_src, mem_read, mem_write, reg_write}.
REQ-009 flush  in  1  taken branch/jump from EX; kill instruction entering EX.
REQ-010 ex_busy  in  1  EX cannot accept a new instruction this cycle.
REQ-011 memwb_reg_write / memwb_rd / memwb_data  in  1 / 4 / DATA_W  writeback port.
REQ-012 idex_valid, idex_rs1, idex_rs2, idex_rd, idex_rs1_data, idex_rs2_data, idex_imm, idex_ctrl  out  widths as the ID inputs  registered ID/EX contents; idex_rs1/idex_rs2 feed the forwarding unit.
REQ-013 stall_if_id  out  1  combinational; freezes PC and IF/ID.
REQ-014 bubble_count  out  16  load-use bubbles inserted (present only under configuration, see REQ-027).

Function
REQ-015 Per-cycle action priority: flush > hold > bubble > capture.
REQ-016 Load-use hazard (lu) = idex_valid & idex_ctrl[2] & (idex_rd != 0) & id_valid & (idex_rd == id_rs1 | idex_rd == id_rs2).
REQ-017 Flush: next idex_valid = 0 and idex_ctrl = 0; other fields don't-care; stall_if_id = 0 regardless of lu or ex_busy.
REQ-018 Hold (ex_busy=1, flush=0): all idex_* registers keep their values; stall_if_id = 1.
REQ-019 Bubble (lu=1, ex_busy=0, flush=0): idex_valid = 0 and idex_ctrl = 0 next cycle; stall_if_id = 1; ID instruction is re-presented next cycle, and lu clears because idex now holds a bubble.
REQ-020 Capture (otherwise): all ID fields registered; idex_valid = id_valid; when id_valid = 0, idex_ctrl is loaded as 0.
REQ-021 Writeback bypass at capture: if memwb_reg_write & (memwb_rd != 0) & (memwb_rd == id_rs1), idex_rs1_data takes memwb_data instead of id_rs1_data; same rule independently for rs2.
REQ-022 Register 0 never bypasses and never triggers lu.
REQ-023 Latency: one cycle from ID inputs to idex_* outputs; stall_if_id has zero latency and is a pure function of current inputs and state.
REQ-024 A bubble never reaches EX with reg_write, mem_read or mem_write set.

Reset
REQ-025 rst_n low asynchronously forces idex_valid = 0 and all idex_* = 0, and bubble_count = 0 when present.
REQ-026 During reset stall_if_id = 0; the first capture occurs on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro IDEX_PERF_CNT_EN: when defined, bubble_count increments by 1 on each bubble action (REQ-019) and saturates at 16'hFFFF; hold and flush do not count. When undefined, the port and counter logic are absent and all other behaviour is identical.

Verification
REQ-028 Load-use: LD r3 in EX (idex_ctrl[2]=1, idex_rd=3); ID ADD with rs1=3 -> stall_if_id=1, next idex_valid=0, idex_ctrl=0; following cycle ADD captured; bubble_count=1.
REQ-029 Flush with lu and ex_busy all high -> next idex_valid=0, stall_if_id=0, bubble_count unchanged.
REQ-030 ex_busy high for 3 cycles with idex_rd=5, idex_rs1_data=16'h1234 -> outputs unchanged for 3 cycles, stall_if_id=1 throughout.
REQ-031 memwb_reg_write=1, memwb_rd=7, memwb_data=16'hBEEF, id_rs2=7, id_rs2_data=16'h0000 -> idex_rs2_data=16'hBEEF after capture; with memwb_rd=0 -> 16'h0000.
REQ-032 LD r0 in EX and ID rs1=0 -> no stall, normal capture.
REQ-033 rst_n pulsed low mid-hold -> outputs zero immediately, asynchronously; after release, capture resumes on the first edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold, flush and
// writeback bypass. Optional bubble counter under IDEX_PERF_CNT_EN.
// Ports: clk, rst_n, id_* (ID bundle in), flush, ex_busy, memwb_* (WB port),
//        idex_* (registered ID/EX bundle out), stall_if_id, bubble_count (opt).
module id_ex_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_rs1,
  input  logic [3:0]        id_rs2,
  input  logic [3:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_busy,
  input  logic              memwb_reg_write,
  input  logic [3:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              idex_valid,
  output logic [3:0]        idex_rs1,
  output logic [3:0]        idex_rs2,
  output logic [3:0]        idex_rd,
  output logic [DATA_W-1:0] idex_rs1_data,
  output logic [DATA_W-1:0] idex_rs2_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [7:0]        idex_ctrl,
`ifdef IDEX_PERF_CNT_EN
  output logic [15:0]       bubble_count,
`endif
  output logic              stall_if_id
);

  logic              valid_q, valid_d;
  logic [3:0]        rs1_q, rs1_d;
  logic [3:0]        rs2_q, rs2_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] d2_q, d2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [7:0]        ctrl_q, ctrl_d;

  logic lu;
  logic byp1;
  logic byp2;
  logic bubble;

  assign lu = valid_q & ctrl_q[2] & (rd_q != 4'd0) & id_valid &
              ((rd_q == id_rs1) | (rd_q == id_rs2));

  assign byp1 = memwb_reg_write & (memwb_rd != 4'd0) & (memwb_rd == id_rs1);
  assign byp2 = memwb_reg_write & (memwb_rd != 4'd0) & (memwb_rd == id_rs2);

  assign bubble = ~flush & ~ex_busy & lu;

  // Gated by rst_n so the stall is low while reset is held.
  assign stall_if_id = rst_n & ~flush & (ex_busy | lu);

  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    priority case (1'b1)
      flush: begin
        valid_d = 1'b0;
        ctrl_d  = 8'h00;
      end
      ex_busy: begin
      end
      lu: begin
        valid_d = 1'b0;
        ctrl_d  = 8'h00;
      end
      default: begin
        valid_d = id_valid;
        rs1_d   = id_rs1;
        rs2_d   = id_rs2;
        rd_d    = id_rd;
        d1_d    = byp1 ? memwb_data : id_rs1_data;
        d2_d    = byp2 ? memwb_data : id_rs2_data;
        imm_d   = id_imm;
        ctrl_d  = id_valid ? id_ctrl : 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_rs1      = rs1_q;
  assign idex_rs2      = rs2_q;
  assign idex_rd       = rd_q;
  assign idex_rs1_data = d1_q;
  assign idex_rs2_data = d2_q;
  assign idex_imm      = imm_q;
  assign idex_ctrl     = ctrl_q;

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bubble_count = cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid;
  logic [3:0]   id_rs1, id_rs2, id_rd;
  logic [W-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [7:0]   id_ctrl;
  logic         flush, ex_busy;
  logic         memwb_reg_write;
  logic [3:0]   memwb_rd;
  logic [W-1:0] memwb_data;
  logic         idex_valid;
  logic [3:0]   idex_rs1, idex_rs2, idex_rd;
  logic [W-1:0] idex_rs1_data, idex_rs2_data, idex_imm;
  logic [7:0]   idex_ctrl;
  logic         stall_if_id;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0]  bubble_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .ex_busy(ex_busy),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .idex_valid(idex_valid), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_rs1_data(idex_rs1_data),
    .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
    .idex_ctrl(idex_ctrl),
`ifdef IDEX_PERF_CNT_EN
    .bubble_count(bubble_count),
`endif
    .stall_if_id(stall_if_id)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_known=0 means the data fields are don't-care (after flush/bubble).
  logic         m_valid;
  logic [3:0]   m_rs1, m_rs2, m_rd;
  logic [W-1:0] m_d1, m_d2, m_imm;
  logic [7:0]   m_ctrl;
  bit           m_known;
  int           m_cnt;

  function automatic bit model_lu();
    return m_valid && m_ctrl[2] && m_rd != 0 && id_valid &&
           (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  function automatic bit model_stall();
    return rst_n && !flush && (ex_busy || model_lu());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0;
      m_known = 1; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_ctrl = 0; m_known = 0;
    end else if (ex_busy) begin
      // everything held
    end else if (model_lu()) begin
      m_valid = 0; m_ctrl = 0; m_known = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_imm = id_imm;
      m_d1 = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs1)
             ? memwb_data : id_rs1_data;
      m_d2 = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs2)
             ? memwb_data : id_rs2_data;
      m_ctrl = id_valid ? id_ctrl : 8'h00;
      m_known = 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("valid", {31'b0, idex_valid}, {31'b0, m_valid});
    chk("ctrl", {24'b0, idex_ctrl}, {24'b0, m_ctrl});
    chk("stall", {31'b0, stall_if_id}, {31'b0, model_stall()});
    if (m_known) begin
      chk("rs1", {28'b0, idex_rs1}, {28'b0, m_rs1});
      chk("rs2", {28'b0, idex_rs2}, {28'b0, m_rs2});
      chk("rd", {28'b0, idex_rd}, {28'b0, m_rd});
      chk("d1", {16'b0, idex_rs1_data}, {16'b0, m_d1});
      chk("d2", {16'b0, idex_rs2_data}, {16'b0, m_d2});
      chk("imm", {16'b0, idex_imm}, {16'b0, m_imm});
    end
`ifdef IDEX_PERF_CNT_EN
    chk("cnt", {16'b0, bubble_count}, m_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_ctrl = 0;
    flush = 0; ex_busy = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic set_id(logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd,
                        logic [W-1:0] d1, logic [W-1:0] d2,
                        logic [7:0] ctrl);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = 16'h0042;
    id_ctrl = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_cnt(string n, int e);
`ifdef IDEX_PERF_CNT_EN
    chk(n, {16'b0, bubble_count}, e);
`else
    if (e < 0) chk(n, 0, 1);
`endif
  endtask

  initial begin
    rst_n = 0;
    idle();
    ex_busy = 1;
    #1;
    chk("rst_valid", {31'b0, idex_valid}, 0);
    chk("rst_stall", {31'b0, stall_if_id}, 0);
    chk("rst_d1", {16'b0, idex_rs1_data}, 0);
    @(negedge clk);
    rst_n = 1;
    idle();

    // load-use: LD r3 then ADD r5 <- r3
    set_id(4'd1, 4'd2, 4'd3, 16'h0001, 16'h0002, 8'h05);
    step();
    chk("lu_ld_in_ex", {28'b0, idex_rd}, 3);
    set_id(4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 8'h01);
    #1;
    chk("lu_stall", {31'b0, stall_if_id}, 1);
    step();
    chk("lu_bub_valid", {31'b0, idex_valid}, 0);
    chk("lu_bub_ctrl", {24'b0, idex_ctrl}, 0);
    chk("lu_stall_clr", {31'b0, stall_if_id}, 0);
    chk_cnt("lu_cnt", 1);
    step();
    chk("lu_add_valid", {31'b0, idex_valid}, 1);
    chk("lu_add_rd", {28'b0, idex_rd}, 5);
    chk("lu_add_d1", {16'b0, idex_rs1_data}, 16'h1111);

    // flush beats lu and ex_busy
    set_id(4'd1, 4'd2, 4'd3, 16'h0001, 16'h0002, 8'h05);
    step();
    set_id(4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 8'h01);
    flush = 1; ex_busy = 1;
    #1;
    chk("fl_stall", {31'b0, stall_if_id}, 0);
    step();
    chk("fl_valid", {31'b0, idex_valid}, 0);
    chk_cnt("fl_cnt", 1);
    flush = 0; ex_busy = 0;

    // hold for three cycles
    set_id(4'd1, 4'd2, 4'd5, 16'h1234, 16'h0000, 8'h01);
    step();
    ex_busy = 1;
    set_id(4'd6, 4'd7, 4'd9, 16'hAAAA, 16'hBBBB, 8'h09);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", {31'b0, stall_if_id}, 1);
      step();
      chk("hold_rd", {28'b0, idex_rd}, 5);
      chk("hold_d1", {16'b0, idex_rs1_data}, 16'h1234);
    end
    ex_busy = 0;

    // writeback bypass
    set_id(4'd1, 4'd7, 4'd2, 16'h0001, 16'h0000, 8'h01);
    memwb_reg_write = 1; memwb_rd = 7; memwb_data = 16'hBEEF;
    step();
    chk("byp_rs2", {16'b0, idex_rs2_data}, 16'hBEEF);
    chk("byp_rs1", {16'b0, idex_rs1_data}, 16'h0001);
    memwb_rd = 0;
    id_rs2 = 0;
    step();
    chk("byp_r0", {16'b0, idex_rs2_data}, 16'h0000);
    memwb_reg_write = 0;

    // LD r0 never stalls
    set_id(4'd1, 4'd2, 4'd0, 16'h0001, 16'h0002, 8'h05);
    step();
    set_id(4'd0, 4'd4, 4'd8, 16'h5555, 16'h6666, 8'h01);
    #1;
    chk("r0_stall", {31'b0, stall_if_id}, 0);
    step();
    chk("r0_valid", {31'b0, idex_valid}, 1);
    chk("r0_rd", {28'b0, idex_rd}, 8);

    // async reset mid-hold
    ex_busy = 1;
    step();
    #1;
    rst_n = 0;
    #1;
    chk("ar_valid", {31'b0, idex_valid}, 0);
    chk("ar_rd", {28'b0, idex_rd}, 0);
    chk("ar_d1", {16'b0, idex_rs1_data}, 0);
    chk("ar_stall", {31'b0, stall_if_id}, 0);
    chk_cnt("ar_cnt", 0);
    @(negedge clk);
    rst_n = 1;
    ex_busy = 0;
    set_id(4'd1, 4'd2, 4'd6, 16'h7777, 16'h8888, 8'h01);
    step();
    chk("ar_cap_valid", {31'b0, idex_valid}, 1);
    chk("ar_cap_rd", {28'b0, idex_rd}, 6);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs1 = 4'($urandom_range(0, 3));
      id_rs2 = 4'($urandom_range(0, 3));
      id_rd = 4'($urandom_range(0, 3));
      id_rs1_data = 16'($urandom);
      id_rs2_data = 16'($urandom);
      id_imm = 16'($urandom);
      id_ctrl = 8'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      ex_busy = ($urandom_range(0, 4) == 0);
      memwb_reg_write = $urandom_range(0, 1) == 1;
      memwb_rd = 4'($urandom_range(0, 3));
      memwb_data = 16'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
